packed_lane_accumulator: RTL and testbench

//   Sequential accumulator directly downstream of the 32-bit packed-lane adder in the mixed-precision MAC path.

---
 rtl/packed_lane_accumulator.sv | 120 ++++++++++++
 tb/tb_packed_lane_accumulator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/packed_lane_accumulator.sv
// Beat accumulator behind the packed-lane adder: sums a programmed number of beats
// as one wrapping 32-bit lane, or as two saturating signed 16-bit lanes in mode_3.
//
// state | meaning
// IDLE  | waiting for start_i; len and mode captured here
// ACC   | accepting adder results, counting beats down to zero
// DONE  | holding the final sum on out_data_o until the consumer takes it
module packed_lane_accumulator #(
    parameter  int MAX_LEN = 256,
    localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             mode_3_i,
    input  logic             abort_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_data_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mode_q;

    logic [CNT_W-1:0] len_clamped;
    logic [31:0]      sum_normal;
    logic [16:0]      lane0_sum, lane1_sum;
    logic [15:0]      lane0_sat, lane1_sat;
    logic [31:0]      acc_next;
    logic             beat;
    logic             last_beat;

    // Collapse a 17-bit signed lane sum back into 16 bits, clipping on overflow.
    function automatic logic [15:0] sat16(input logic [16:0] s);
        if (s[16] != s[15]) begin
            sat16 = s[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            sat16 = s[15:0];
        end
    endfunction

    always_comb begin
        len_clamped = (len_i > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : len_i;
        sum_normal  = acc_q + in_data_i;
        lane0_sum   = {acc_q[15], acc_q[15:0]}  + {{5{in_data_i[11]}}, in_data_i[11:0]};
        lane1_sum   = {acc_q[31], acc_q[31:16]} + {{5{in_data_i[27]}}, in_data_i[27:16]};
        lane0_sat   = sat16(lane0_sum);
        lane1_sat   = sat16(lane1_sum);
        acc_next    = mode_q ? {lane1_sat, lane0_sat} : sum_normal;
    end

    assign in_ready_o  = (state_q == ACC);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q == ACC) || (state_q == DONE);
    assign beat        = in_ready_o && in_valid_i;
    assign last_beat   = beat && (cnt_q == CNT_W'(1));

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start_i) state_d = (len_clamped == '0) ? DONE : ACC;
                ACC:  if (last_beat) state_d = DONE;
                DONE: if (out_ready_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            out_data_o <= '0;
        end else if (abort_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        acc_q  <= '0;
                        cnt_q  <= len_clamped;
                        mode_q <= mode_3_i;
                        if (len_clamped == '0) out_data_o <= '0;
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc_q <= acc_next;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (last_beat) out_data_o <= acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_packed_lane_accumulator.sv
// Directed bench for packed_lane_accumulator: hand-computed sums in both lane formats,
// reset/abort/back-pressure/zero-length/clamp corner cases.
module tb_packed_lane_accumulator;

    localparam int MAX_LEN = 256;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             start_i;
    logic [CNT_W-1:0] len_i;
    logic             mode_3_i;
    logic             abort_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      in_data_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [31:0]      out_data_o;
    logic             busy_o;

    int n_checks = 0;
    int n_errors = 0;

    packed_lane_accumulator #(.MAX_LEN(MAX_LEN)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .len_i       (len_i),
        .mode_3_i    (mode_3_i),
        .abort_i     (abort_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_op(input int len, input logic m3);
        start_i  = 1'b1;
        len_i    = CNT_W'(len);
        mode_3_i = m3;
        tick();
        start_i  = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d);
        in_valid_i = 1'b1;
        in_data_i  = d;
        tick();
    endtask

    task automatic drain();
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
    endtask

    function automatic logic [31:0] pack3(input logic [11:0] l1, input logic [11:0] l0);
        pack3 = {4'hA, l1, 4'h5, l0};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        len_i       = '0;
        mode_3_i    = 1'b0;
        abort_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
        #3;
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_in_ready",  32'(in_ready_o),  32'd0);
        check("rst_busy",      32'(busy_o),      32'd0);
        check("rst_out_data",  out_data_o,       32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Reset in the middle of an accumulation
        start_op(8, 1'b0);
        check("t1_busy_acc", 32'(busy_o), 32'd1);
        for (int i = 0; i < 3; i++) beat(32'd10);
        in_valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("t1_rst_in_ready", 32'(in_ready_o),  32'd0);
        check("t1_rst_busy",     32'(busy_o),      32'd0);
        check("t1_rst_valid",    32'(out_valid_o), 32'd0);
        check("t1_rst_data",     out_data_o,       32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        start_op(2, 1'b0);
        beat(32'd7);
        beat(32'd8);
        in_valid_i = 1'b0;
        check("t1_after_valid", 32'(out_valid_o), 32'd1);
        check("t1_after_data",  out_data_o,       32'd15);
        drain();

        // Normal mode, back-to-back beats including a negative value
        start_op(4, 1'b0);
        check("t2_in_ready", 32'(in_ready_o), 32'd1);
        beat(32'd1);
        beat(32'd2);
        beat(32'd3);
        check("t2_valid_early", 32'(out_valid_o), 32'd0);
        beat(32'hFFFF_FFFF);
        in_valid_i = 1'b0;
        check("t2_valid",    32'(out_valid_o), 32'd1);
        check("t2_data",     out_data_o,       32'h0000_0005);
        check("t2_ready_dn", 32'(in_ready_o),  32'd0);
        drain();
        check("t2_idle_valid", 32'(out_valid_o), 32'd0);
        check("t2_idle_busy",  32'(busy_o),      32'd0);

        // Normal-mode wrap
        start_op(2, 1'b0);
        beat(32'h7FFF_FFFF);
        beat(32'h0000_0001);
        in_valid_i = 1'b0;
        check("t3_data", out_data_o, 32'h8000_0000);
        drain();

        // mode_3 lanes, ignored nibbles set nonzero
        start_op(3, 1'b1);
        beat(pack3(12'hFFF, 12'h064));
        beat(pack3(12'hFFF, 12'hED4));
        beat(pack3(12'hFFF, 12'h032));
        in_valid_i = 1'b0;
        check("t4_valid", 32'(out_valid_o), 32'd1);
        check("t4_data",  out_data_o,       32'hFFFD_FF6A);
        drain();

        // mode_3 saturation in both directions
        start_op(200, 1'b1);
        for (int i = 0; i < 200; i++) beat(pack3(12'h800, 12'h7FF));
        in_valid_i = 1'b0;
        check("t5_data", out_data_o, 32'h8000_7FFF);

        // Back-pressure in DONE while start pulses are ignored
        for (int i = 0; i < 5; i++) begin
            start_i = (i % 2 == 0);
            len_i   = CNT_W'(3);
            tick();
            check("t6_hold_valid", 32'(out_valid_o), 32'd1);
            check("t6_hold_data",  out_data_o,       32'h8000_7FFF);
        end
        start_i = 1'b0;
        drain();
        check("t6_idle_busy", 32'(busy_o), 32'd0);
        tick();
        check("t6_no_queue_busy", 32'(busy_o), 32'd0);

        // Abort coincident with a valid beat
        start_op(2, 1'b0);
        beat(32'd5);
        abort_i = 1'b1;
        beat(32'd9);
        abort_i    = 1'b0;
        in_valid_i = 1'b0;
        check("t7_busy",     32'(busy_o),      32'd0);
        check("t7_in_ready", 32'(in_ready_o),  32'd0);
        check("t7_valid",    32'(out_valid_o), 32'd0);
        start_op(1, 1'b0);
        beat(32'd4);
        in_valid_i = 1'b0;
        check("t7_fresh_data", out_data_o, 32'd4);
        drain();

        // Zero-length request
        start_i = 1'b1;
        len_i   = '0;
        #1;
        check("t8_valid_pre", 32'(out_valid_o), 32'd0);
        tick();
        start_i = 1'b0;
        check("t8_valid", 32'(out_valid_o), 32'd1);
        check("t8_data",  out_data_o,       32'd0);
        drain();

        // Over-length request clamps to MAX_LEN beats
        start_op(300, 1'b0);
        for (int i = 0; i < 255; i++) beat(32'd1);
        check("clamp_valid_early", 32'(out_valid_o), 32'd0);
        beat(32'd1);
        in_valid_i = 1'b0;
        check("clamp_valid", 32'(out_valid_o), 32'd1);
        check("clamp_data",  out_data_o,       32'd256);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
